irq_pending_ctrl: RTL
=====================

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 Parameter DEFAULT_MASK, 8'hFF, mask register value after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_i  input  8  raw request lines, lane 7 highest priority.
REQ-005 mask_we_i  input  1  mask write strobe.
REQ-006 mask_wdata_i  input  8  new mask value; 1 = lane enabled.
REQ-007 code_o  output  3  index of offered lane (Y2..Y0 order, bit 2 = MSB).
REQ-008 valid_o  output  1  code_o holds a valid offer.
REQ-009 ready_i  input  1  consumer accepts the offer when valid_o and ready_i are both high.
REQ-010 idle_o  output  1  no eligible request and no offer outstanding.
REQ-011 pending_o  output  8  current pending register, for observation.
REQ-012 ovf_o  output  8  per-lane sticky overflow flags.
REQ-013 ovf_clr_i  input  1  clears all ovf_o bits.

Function
REQ-014 req_i is registered into req_q each cycle; pending[n] is set when req_i[n]=1 and req_q[n]=0 (rising edge).
REQ-015 eligible = pending & mask; selection is highest set index of eligible, matching 8-to-3 priority encoding (lane 7 wins).
REQ-016 The FSM has two states: IDLE and OFFER.
REQ-017 IDLE: if eligible != 0, the selected index is latched into code_o, valid_o goes high next cycle, and the FSM enters OFFER; otherwise it stays in IDLE.
REQ-018 OFFER: code_o and valid_o are held stable until handshake, even if a higher-priority lane becomes pending or the offered lane becomes masked.
REQ-019 Handshake cycle (valid_o & ready_i): pending[code_o] is cleared, valid_o drops next cycle, and the FSM returns to IDLE; maximum throughput is one grant per 2 cycles.
REQ-020 A new edge on lane code_o in the handshake cycle leaves pending[code_o] set (set wins over clear).
REQ-021 idle_o = 1 when state is IDLE and eligible == 0; it is combinational from registered state.
REQ-022 mask_we_i loads the mask on the next edge; the new mask affects selection from the following cycle.
REQ-023 code_o holds its last value when valid_o = 0.

Reset
REQ-024 On rst_n low: req_q=0, pending=0, mask=DEFAULT_MASK, state=IDLE, code_o=0, valid_o=0, ovf_o=0; idle_o=1.
REQ-025 Reset mid-offer discards the offer and all pending requests immediately.
REQ-026 req_i held high across reset release registers as an edge on the first clock after release.

Configuration
REQ-027 Macro IRQ_OVERFLOW_EN defined: ovf_o[n] sets when an edge arrives on lane n while pending[n] is already set and is not being cleared that cycle; it clears on ovf_clr_i (set wins when both occur in the same cycle).
REQ-028 Macro IRQ_OVERFLOW_EN undefined: ovf_o is tied to 0, ovf_clr_i is ignored, and no overflow flops exist.

Structure
REQ-029 A shared package irq_pkg holds NUM_LANES=8, CODE_W=3, the FSM state enum, and the DEFAULT_MASK default constant.
REQ-030 Selection uses one combinational sub-module, prio_enc8 (8-bit in, 3-bit code, any-valid out); all sequential logic stays in irq_pending_ctrl.

Verification
REQ-031 Reset, then pulse req_i=8'h49 for one cycle with ready_i=1 -> grants issue with codes 6, 3, 0, each 2 cycles apart, then idle_o=1 and pending_o=0.
REQ-032 Hold ready_i=0 while offering code 3, then raise req_i[7] -> code_o stays 3 until ready_i is asserted, then code 7 is offered next.
REQ-033 Write mask 8'h0F, then edge on lanes 7 and 2 -> only code 2 is offered; pending_o[7] stays 1; writing mask 8'hFF then offers code 7.
REQ-034 Edge on lane 5 exactly in its handshake cycle -> pending_o[5] stays 1 and code 5 is offered again 2 cycles later.
REQ-035 Assert rst_n=0 while valid_o=1 with pending 8'h30 -> valid_o=0, pending_o=0, and idle_o=1 asynchronously before the next edge.
REQ-036 With IRQ_OVERFLOW_EN, two edges on lane 1 before any grant -> ovf_o=8'h02; ovf_clr_i clears it; without the macro, ovf_o stays 8'h00.

Source files
------------

// File: rtl/irq_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
// Shared constants and types for the interrupt pending controller.
//   NUM_LANES      : number of request lanes
//   CODE_W         : width of a lane index
//   DEFAULT_MASK_C : mask value loaded on reset (all lanes enabled)
//   state_t        : offer FSM state encoding
//   lane_bit()     : one-hot vector for a lane index
// ----------------------------------------------------------------------------
package irq_pkg;

    localparam int NUM_LANES = 8;
    localparam int CODE_W    = 3;

    localparam logic [NUM_LANES-1:0] DEFAULT_MASK_C = 8'hFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    function automatic logic [NUM_LANES-1:0] lane_bit(input logic [CODE_W-1:0] code);
        logic [NUM_LANES-1:0] v;
        v = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc8.sv
// ----------------------------------------------------------------------------
// prio_enc8
// Purely combinational 8-to-3 priority encoder; the highest set bit wins.
// Ports:
//   in     : request vector
//   code   : index of highest set bit (0 when in == 0)
//   any    : at least one bit of in is set
// ----------------------------------------------------------------------------
module prio_enc8
    import irq_pkg::*;
(
    input  logic [NUM_LANES-1:0] in,
    output logic [CODE_W-1:0]    code,
    output logic                 any
);

    // Ascending scan: later (higher) lanes overwrite lower ones.
    always_comb begin
        code = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (in[i]) begin
                code = CODE_W'(i);
            end
        end
    end

    assign any = |in;

endmodule

// File: rtl/irq_pending_ctrl.sv
// ----------------------------------------------------------------------------
// irq_pending_ctrl
// Captures rising edges on eight request lanes into a pending register,
// masks them, and offers the highest-priority eligible lane to a consumer
// with a valid/ready handshake. Optional per-lane sticky overflow flags.
//
// Optional feature macro: IRQ_OVERFLOW_EN
//   defined   : ovf_o flags an edge arriving on an already-pending lane
//   undefined : ovf_o is constant zero and ovf_clr_i is ignored
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   req_i        : raw request lines, lane 7 highest priority
//   mask_we_i    : mask write strobe
//   mask_wdata_i : new mask, 1 = lane enabled
//   code_o       : offered lane index, held when valid_o is low
//   valid_o      : code_o is a live offer
//   ready_i      : consumer accepts the offer when valid_o is high
//   idle_o       : nothing eligible and no offer outstanding
//   pending_o    : pending register
//   ovf_o        : sticky per-lane overflow flags
//   ovf_clr_i    : clears all overflow flags
//
// FSM states
//   state    | meaning
//   ST_IDLE  | no offer; latch highest eligible lane when one exists
//   ST_OFFER | code_o/valid_o frozen until the consumer handshakes
// ----------------------------------------------------------------------------
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter logic [NUM_LANES-1:0] DEFAULT_MASK = DEFAULT_MASK_C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] req_i,
    input  logic                 mask_we_i,
    input  logic [NUM_LANES-1:0] mask_wdata_i,
    output logic [CODE_W-1:0]    code_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 idle_o,
    output logic [NUM_LANES-1:0] pending_o,
    output logic [NUM_LANES-1:0] ovf_o,
    input  logic                 ovf_clr_i
);

    logic [NUM_LANES-1:0] req_q;
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] mask;
    state_t               state;
    logic [CODE_W-1:0]    code_q;
    logic                 valid_q;

    logic [NUM_LANES-1:0] req_edge;
    logic [NUM_LANES-1:0] eligible;
    logic [NUM_LANES-1:0] clr_vec;
    logic [CODE_W-1:0]    sel_code;
    logic                 sel_any;
    logic                 handshake;

    assign req_edge  = req_i & ~req_q;
    assign eligible  = pending & mask;
    assign handshake = valid_q & ready_i;
    assign clr_vec   = handshake ? lane_bit(code_q) : '0;

    prio_enc8 u_prio_enc8 (
        .in   (eligible),
        .code (sel_code),
        .any  (sel_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_i;
        end
    end

    // Set is applied after clear so a fresh edge in the handshake cycle
    // keeps the lane pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | req_edge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= DEFAULT_MASK;
        end else if (mask_we_i) begin
            mask <= mask_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_any) begin
                        code_q  <= sel_code;
                        valid_q <= 1'b1;
                        state   <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IRQ_OVERFLOW_EN
    logic [NUM_LANES-1:0] ovf_q;
    logic [NUM_LANES-1:0] ovf_set;

    // A lane that is being granted this cycle is not overflowing: its
    // previous request is consumed and the new edge takes its place.
    assign ovf_set = req_edge & pending & ~clr_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~{NUM_LANES{ovf_clr_i}}) | ovf_set;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr_i;
    assign ovf_o          = '0;
`endif

    assign code_o    = code_q;
    assign valid_o   = valid_q;
    assign pending_o = pending;
    assign idle_o    = (state == ST_IDLE) && (eligible == '0);

endmodule
